biquad8_coeff_loader: RTL and testbench

//  WISHBONE initiator that programs one biquad8 coefficient target over its 7-bit/32-bit register bus.

---
 rtl/biquad8_pkg.sv | 15 +
 rtl/wb_single_write.sv | 69 ++++++
 rtl/biquad8_coeff_loader.sv | 111 +++++++++++
 tb/tb_biquad8_coeff_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/biquad8_pkg.sv
// biquad8_pkg: register map, loader FSM states and coefficient width shared by the loader
package biquad8_pkg;
    localparam int COEFF_W = 18;
    localparam int NSEG = 5;
    localparam logic [6:0] ADR_UPDATE = 7'h00;
    localparam logic [6:0] ADR_FIR = 7'h04;
    localparam logic [6:0] ADR_F = 7'h10;
    localparam logic [6:0] ADR_G = 7'h14;
    localparam logic [6:0] ADR_FX = 7'h18;
    localparam logic [6:0] ADR_GX = 7'h1C;
    typedef enum logic [2:0] {IDLE, SEG_SEL, WAIT_DATA, WRITE, UPDATE, DONE, ERROR} state_t;
    function automatic logic [6:0] seg_adr(input logic [2:0] s);
        return s == 3'd0 ? ADR_FIR : s == 3'd1 ? ADR_F : s == 3'd2 ? ADR_G : s == 3'd3 ? ADR_FX : ADR_GX;
    endfunction
endpackage

// File: rtl/wb_single_write.sv
// wb_single_write: one WISHBONE write with rty reissue and no-response timeout, reports ok/fail
module wb_single_write #(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        go,
    input  logic [6:0]  adr,
    input  logic [31:0] dat,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [6:0]  adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel,
    output logic        ok,
    output logic        fail
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
    logic cyc_q, rpend;
    logic [RW-1:0] rcnt;
    logic [7:0] tcnt;
    logic [6:0] adr_q;
    logic [31:0] dat_q;
    assign ok = cyc_q & ack & ~err & ~rty;
    assign fail = cyc_q & (err | (rty & rcnt == RMAX) | (~ack & ~rty & tcnt == TLAST));
    assign cyc = cyc_q;
    assign stb = cyc_q;
    assign we = cyc_q;
    assign sel = {4{cyc_q}};
    assign adr_o = adr_q;
    assign dat_o = dat_q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_q <= 1'b0;
            rpend <= 1'b0;
            rcnt <= '0;
            tcnt <= '0;
            adr_q <= '0;
            dat_q <= '0;
        end else if (go) begin
            cyc_q <= 1'b1;
            rcnt <= '0;
            tcnt <= '0;
            adr_q <= adr;
            dat_q <= dat;
        end else if (rpend) begin
            cyc_q <= 1'b1;
            rpend <= 1'b0;
        end else if (cyc_q) begin
            if (ok | fail) begin
                cyc_q <= 1'b0;
            end else if (rty) begin
                cyc_q <= 1'b0;
                rpend <= 1'b1;
                rcnt <= rcnt + 1'b1;
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader: streams coefficients into the biquad8 register segments, then triggers the update
module biquad8_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int NFIR = 8,
    parameter int NF = 4,
    parameter int NG = 4,
    parameter int NFX = 4,
    parameter int NGX = 4,
    parameter int UPDATE_EN = 1,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    input  logic [COEFF_W-1:0] s_dat_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [6:0]         wb_adr_o,
    output logic [31:0]        wb_dat_o,
    output logic [3:0]         wb_sel_o,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i,
    input  logic [31:0]        wb_dat_i
);
    state_t state, nxt;
    logic [2:0] seg;
    logic [7:0] wcnt, seg_n;
    logic go, ok, fail;
    logic [6:0] go_adr;
    logic [31:0] go_dat;
    logic unused_dat;
    assign unused_dat = ^wb_dat_i;
    assign busy_o = state != IDLE;
    assign done_o = state == DONE;
    assign s_ready_o = state == WAIT_DATA;
    assign seg_n = seg == 3'd0 ? 8'(NFIR) : seg == 3'd1 ? 8'(NF) : seg == 3'd2 ? 8'(NG) :
                   seg == 3'd3 ? 8'(NFX) : 8'(NGX);
    always_comb begin
        nxt = state;
        go = 1'b0;
        go_adr = seg_adr(seg);
        go_dat = {{(32-COEFF_W){1'b0}}, s_dat_i};
        case (state)
            IDLE: nxt = start_i ? SEG_SEL : IDLE;
            SEG_SEL: nxt = seg == 3'(NSEG) ? (UPDATE_EN != 0 ? UPDATE : DONE) : seg_n != 8'd0 ? WAIT_DATA : SEG_SEL;
            WAIT_DATA: begin
                go = s_valid_i;
                nxt = s_valid_i ? WRITE : WAIT_DATA;
            end
            WRITE: nxt = fail ? ERROR : !ok ? WRITE : seg == 3'(NSEG) ? DONE : wcnt == 8'd1 ? SEG_SEL : WAIT_DATA;
            UPDATE: begin
                go = 1'b1;
                go_adr = ADR_UPDATE;
                go_dat = 32'h1;
                nxt = WRITE;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            seg <= '0;
            wcnt <= '0;
            err_o <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && start_i) begin
                seg <= '0;
                err_o <= 1'b0;
            end
            // empty segments advance here without issuing any bus cycle
            if (state == SEG_SEL && seg != 3'(NSEG)) begin
                if (seg_n == 8'd0) seg <= seg + 3'd1;
                else wcnt <= seg_n;
            end
            if (state == WRITE && ok && seg != 3'(NSEG)) begin
                wcnt <= wcnt - 8'd1;
                if (wcnt == 8'd1) seg <= seg + 3'd1;
            end
            if (nxt == ERROR) err_o <= 1'b1;
        end
    end
    wb_single_write #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) u_wr (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .go(go),
        .adr(go_adr),
        .dat(go_dat),
        .ack(wb_ack_i),
        .err(wb_err_i),
        .rty(wb_rty_i),
        .cyc(wb_cyc_o),
        .stb(wb_stb_o),
        .we(wb_we_o),
        .adr_o(wb_adr_o),
        .dat_o(wb_dat_o),
        .sel(wb_sel_o),
        .ok(ok),
        .fail(fail)
    );
endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// tb_biquad8_coeff_loader: random streams and scripted target responses, scoreboard of expected writes
module tb_biquad8_coeff_loader;
    logic clk = 0, rst = 1, start = 0, s_valid = 0, ack = 0, err = 0, rty = 0;
    logic [17:0] s_dat = 0;
    logic [31:0] rdat = 0;
    logic busy, done, err_o, s_ready, cyc, stb, we;
    logic [6:0] adr;
    logic [31:0] dat;
    logic [3:0] sel;
    logic b_rst = 1, b_start = 0, b_ack = 0;
    logic b_busy, b_done, b_err, b_ready, b_cyc, b_stb, b_we;
    logic [6:0] b_adr;
    logic [31:0] b_dat;
    logic [3:0] b_sel;

    always #5 clk = ~clk;

    typedef struct {logic [6:0] a; logic [31:0] d;} wr_t;
    wr_t exp_q[$];
    logic [17:0] stream_q[$];
    int att_q[$];
    int n_chk = 0, n_fail = 0;
    int hold = 0, noresp = 0, err_at = -1, rty_at = -1, rty_n = 0, n_ack = 0, tries = 0, dly = 0;
    int n_done = 0, n_att = 0, cur_att = 0, run_len = 0, last_run = 0;
    int b_nw = 0, b_n10 = 0, b_n00 = 0, b_ndone = 0;
    bit hs_pend = 0, prev_hs = 0, prev_resp = 0, prev_done = 0, prev_stb = 0;
    int cnt[5] = '{8, 4, 4, 4, 4};
    logic [6:0] sadr[5] = '{7'h04, 7'h10, 7'h14, 7'h18, 7'h1C};

    biquad8_coeff_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err_o),
        .s_dat_i(s_dat), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_dat_o(dat), .wb_sel_o(sel),
        .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty), .wb_dat_i(rdat)
    );

    biquad8_coeff_loader #(.NF(0), .UPDATE_EN(0)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(b_rst), .start_i(b_start), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
        .s_dat_i(18'h2A), .s_valid_i(1'b1), .s_ready_o(b_ready),
        .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_we), .wb_adr_o(b_adr), .wb_dat_o(b_dat), .wb_sel_o(b_sel),
        .wb_ack_i(b_ack), .wb_err_i(1'b0), .wb_rty_i(1'b0), .wb_dat_i(32'h0)
    );

    task automatic check(input bit good, input string name, input longint act, input longint exp);
        n_chk++;
        if (!good) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        check(act == exp, name, act, exp);
    endtask

    // stream source: pops a word once the loader has taken it
    initial forever begin
        @(negedge clk);
        if (hs_pend && stream_q.size() > 0) void'(stream_q.pop_front());
        s_valid = stream_q.size() > 0 && hold == 0 && $urandom_range(3) != 0;
        s_dat = stream_q.size() > 0 ? stream_q[0] : 18'h0;
        hs_pend = s_valid && s_ready;
    end

    // target: random latency, scripted err/rty per acked-write index
    initial forever begin
        @(negedge clk);
        ack = 0; err = 0; rty = 0; rdat = $urandom();
        if (stb && noresp == 0) begin
            if (dly > 0) dly--;
            else begin
                dly = $urandom_range(2);
                if (n_ack == err_at) err = 1;
                else if (n_ack == rty_at && tries < rty_n) begin rty = 1; tries++; end
                else begin ack = 1; n_ack++; tries = 0; end
            end
        end
    end

    // monitor: compares each bus attempt against the head of the scoreboard
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (prev_hs) chk("cyc high and ready low after accept", {cyc, s_ready}, 2'b10);
            if (prev_resp) chk("stb low after response", stb, 0);
            if (done) begin chk("done single pulse", prev_done, 0); n_done++; end
            if (stb) begin
                run_len++;
                if (!prev_stb) begin
                    n_att++; cur_att++;
                    if (exp_q.size() == 0) check(0, "write not expected", adr, 0);
                    else begin
                        chk("adr", adr, exp_q[0].a);
                        chk("dat", dat, exp_q[0].d);
                        chk("cyc/we/sel", {cyc, we, sel}, 6'h3F);
                    end
                end
                if (ack && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    att_q.push_back(cur_att);
                    cur_att = 0;
                end
            end else begin
                if (prev_stb) last_run = run_len;
                run_len = 0;
            end
            prev_hs = s_valid && s_ready;
            prev_resp = stb && (ack || err || rty);
            prev_done = done;
            prev_stb = stb;
        end else begin
            prev_hs = 0; prev_resp = 0; prev_done = 0; prev_stb = 0; run_len = 0;
        end
    end

    // second loader (no F chain, no update) against an always-ack target
    initial forever begin
        @(negedge clk);
        b_ack = b_stb;
        #1;
        if (!b_rst) begin
            if (b_stb && b_ack) begin
                b_nw++;
                if (b_adr == 7'h10) b_n10++;
                if (b_adr == 7'h00) b_n00++;
            end
            if (b_done) b_ndone++;
        end
    end

    task automatic load(input bit seq);
        int k = 0;
        logic [17:0] w[24];
        for (int i = 0; i < 24; i++) begin
            w[i] = seq ? 18'(i + 1) : 18'($urandom());
            stream_q.push_back(w[i]);
        end
        for (int s = 0; s < 5; s++)
            for (int j = 0; j < cnt[s]; j++) begin
                exp_q.push_back(wr_t'{sadr[s], {14'b0, w[k]}});
                k++;
            end
        exp_q.push_back(wr_t'{7'h00, 32'h1});
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_end(input string name);
        int i = 0;
        while (!done && !err_o && i < 3000) begin @(negedge clk); i++; end
        check(i < 3000, {name, " ends within bound"}, i, 3000);
    endtask

    task automatic flush;
        exp_q.delete();
        stream_q.delete();
        cur_att = 0;
    endtask

    task automatic run_ok(input string name, input bit seq, input bit stall);
        int d0 = n_done;
        int a0;
        n_ack = 0; tries = 0; att_q.delete();
        hold = stall;
        load(seq);
        pulse_start;
        chk({name, " err_o clear after start"}, err_o, 0);
        if (stall) begin
            a0 = n_att;
            repeat (20) @(negedge clk);
            chk("no cycle while stalled", n_att - a0, 0);
            chk("busy/ready while stalled", {busy, s_ready}, 2'b11);
            hold = 0;
        end
        wait_end(name);
        chk({name, " done"}, done, 1);
        @(negedge clk);
        chk({name, " busy low after done"}, busy, 0);
        chk({name, " one done pulse"}, n_done - d0, 1);
        chk({name, " all writes seen"}, exp_q.size(), 0);
        chk({name, " err_o"}, err_o, 0);
    endtask

    task automatic run_err(input string name);
        n_ack = 0; tries = 0;
        load(0);
        pulse_start;
        wait_end(name);
        chk({name, " err_o"}, err_o, 1);
        chk({name, " no done"}, done, 0);
    endtask

    initial begin
        int a0, d0, i;
        repeat (3) @(negedge clk);
        chk("reset outputs", {busy, done, err_o, s_ready, cyc, stb, we, sel, adr, dat}, 0);
        chk("reset dut2 outputs", {b_busy, b_done, b_err, b_cyc}, 0);
        rst = 0; b_rst = 0;
        @(negedge clk) b_start = 1;
        @(negedge clk) b_start = 0;

        run_ok("seq", 1, 0);
        run_ok("stall", 0, 1);

        err_at = 2;
        run_err("err3");
        a0 = n_att; d0 = n_done;
        repeat (20) @(negedge clk);
        chk("no cycles after err", n_att - a0, 0);
        chk("no done after err", n_done - d0, 0);
        chk("words left after err", exp_q.size(), 23);
        chk("busy after err", busy, 0);
        err_at = -1;
        flush;
        run_ok("after err", 0, 0);

        rty_at = 4; rty_n = 2;
        run_ok("retry2", 0, 0);
        chk("word 5 attempts", att_q.size() > 4 ? att_q[4] : 0, 3);
        rty_at = $urandom_range(24); rty_n = 3;
        run_ok("retry max", 0, 0);
        rty_n = 4;
        run_err("retry over");
        rty_at = -1; rty_n = 0;
        flush;

        noresp = 1;
        run_err("timeout");
        @(negedge clk);
        chk("stb cycles before timeout", last_run, 255);
        noresp = 0;
        flush;

        n_ack = 0; tries = 0;
        load(0);
        pulse_start;
        i = 0;
        while (!stb && i < 200) begin @(negedge clk); i++; end
        check(i < 200, "write seen before reset", i, 200);
        #3 rst = 1;
        #1 chk("async reset drops cyc/stb/busy", {cyc, stb, busy}, 0);
        @(negedge clk) rst = 0;
        flush;
        run_ok("after reset", 0, 0);

        chk("dut2 writes", b_nw, 20);
        chk("dut2 F writes", b_n10, 0);
        chk("dut2 update writes", b_n00, 0);
        chk("dut2 done", b_ndone, 1);
        chk("dut2 err", b_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
